// File: rtl/key_debounce_multi.sv
// rtl/key_debounce_multi.sv - per-key debouncer with press/release/auto-repeat pulses
module key_debounce_multi #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000,
  parameter int ACTIVE_LOW      = 1,
  parameter int CNT_W           = 25,
  localparam int KC_W           = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_value,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat,
  output logic              key_flag,
  output logic [KC_W-1:0]   key_code
);

  localparam logic [1:0] S_IDLE         = 2'd0;
  localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] S_PRESSED      = 2'd2;
  localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

  // Raw pin level of a released key, per channel
  localparam logic [N_KEYS-1:0] REL_LVL = (ACTIVE_LOW != 0) ? '1 : '0;

  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_MAX = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_MAX = CNT_W'(REPEAT_PERIOD - 1);

  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;
  logic [1:0]        r_state     [N_KEYS];
  logic [CNT_W-1:0]  r_cnt       [N_KEYS];
  logic [CNT_W-1:0]  r_rpt       [N_KEYS];
  logic [N_KEYS-1:0] r_rpt_first;
  logic [N_KEYS-1:0] r_level;
  logic [N_KEYS-1:0] r_value;
  logic [N_KEYS-1:0] r_press;
  logic [N_KEYS-1:0] r_release;
  logic [N_KEYS-1:0] r_repeat;
  logic [N_KEYS-1:0] w_s;

  // Normalised synchronised input: 1 = pressed
  assign w_s = r_sync2 ^ REL_LVL;

  // Synchronisers plus one independent debounce FSM, counter and repeat timer per key
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync1     <= REL_LVL;
      r_sync2     <= REL_LVL;
      r_rpt_first <= '1;
      r_level     <= '0;
      r_value     <= REL_LVL;
      r_press     <= '0;
      r_release   <= '0;
      r_repeat    <= '0;
      for (int k = 0; k < N_KEYS; k++) begin
        r_state[k] <= S_IDLE;
        r_cnt[k]   <= '0;
        r_rpt[k]   <= '0;
      end
    end else begin
      r_sync1   <= key_in;
      r_sync2   <= r_sync1;
      r_press   <= '0;
      r_release <= '0;
      r_repeat  <= '0;
      for (int k = 0; k < N_KEYS; k++) begin
        case (r_state[k])
          S_IDLE: begin
            if (w_s[k]) begin
              r_state[k] <= S_PRESS_WAIT;
              r_cnt[k]   <= '0;
            end
          end
          S_PRESS_WAIT: begin
            if (!w_s[k]) begin
              r_state[k] <= S_IDLE;
              r_cnt[k]   <= '0;
            end else if (r_cnt[k] == DB_MAX) begin
              r_state[k]     <= S_PRESSED;
              r_press[k]     <= 1'b1;
              r_level[k]     <= 1'b1;
              r_value[k]     <= ~REL_LVL[k];
              r_rpt[k]       <= '0;
              r_rpt_first[k] <= 1'b1;
            end else begin
              r_cnt[k] <= r_cnt[k] + 1'b1;
            end
          end
          S_PRESSED: begin
            if (!w_s[k]) begin
              r_state[k] <= S_RELEASE_WAIT;
              r_cnt[k]   <= '0;
            end else if (REPEAT_EN != 0) begin
              // First pulse after the delay, then on the shorter period
              if (r_rpt[k] == (r_rpt_first[k] ? RD_MAX : RP_MAX)) begin
                r_repeat[k]    <= 1'b1;
                r_rpt[k]       <= '0;
                r_rpt_first[k] <= 1'b0;
              end else begin
                r_rpt[k] <= r_rpt[k] + 1'b1;
              end
            end
          end
          S_RELEASE_WAIT: begin
            // A return to pressed is a bounce: no pulse, repeat timer keeps its value
            if (w_s[k]) begin
              r_state[k] <= S_PRESSED;
              r_cnt[k]   <= '0;
            end else if (r_cnt[k] == DB_MAX) begin
              r_state[k]   <= S_IDLE;
              r_release[k] <= 1'b1;
              r_level[k]   <= 1'b0;
              r_value[k]   <= REL_LVL[k];
            end else begin
              r_cnt[k] <= r_cnt[k] + 1'b1;
            end
          end
          default: begin
            r_state[k] <= S_IDLE;
            r_cnt[k]   <= '0;
          end
        endcase
      end
    end
  end

  // Lowest-numbered key pressing this cycle
  always_comb begin
    key_code = '0;
    for (int k = N_KEYS - 1; k >= 0; k--) begin
      if (r_press[k]) key_code = KC_W'(k);
    end
  end

  assign key_flag    = |r_press;
  assign key_level   = r_level;
  assign key_value   = r_value;
  assign key_press   = r_press;
  assign key_release = r_release;
  assign key_repeat  = r_repeat;

endmodule
